bypass_scoreboard: RTL and testbench
====================================

BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 Parameter REG_COUNT, default 32, number of architectural registers; index width RW = clog2(REG_COUNT).
REQ-002 Parameter DATA_W, default ARCH_LEN, operand width.
REQ-003 Parameter NUM_BYP, default 2, bypass sources; index 0 = youngest (EXE), higher = older (MEM, ...).
REQ-004 Parameter CNT_W, default 2, width of per-register in-flight writer counter.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 in_valid / in_ready  in / out  1  decoded-instruction handshake.
REQ-008 in_src1, in_src2, in_dst  in  RW each  source and destination register indices.
REQ-009 in_wen  in  1  instruction writes in_dst.
REQ-010 rf_data1, rf_data2  in  DATA_W each  register-file read data for in_src1/in_src2.
REQ-011 byp_valid, byp_wen, byp_ready  in  NUM_BYP each  per-source valid, writes-reg, data-available.
REQ-012 byp_dst  in  NUM_BYP x RW;  byp_data  in  NUM_BYP x DATA_W.
REQ-013 wb_valid  in  1;  wb_dst  in  RW;  wb_data  in  DATA_W  retiring write to register file.
REQ-014 flush  in  1  kill all in-flight state.
REQ-015 out_valid / out_ready  out / in  1  issue handshake toward execute.
REQ-016 out_op1, out_op2  out  DATA_W;  out_dst  out  RW;  out_wen  out  1  registered resolved instruction.
REQ-017 stall  out  1  combinational: in_valid high and in_ready low.
REQ-018 stall_cycles  out  32  saturating count of cycles with stall high.

Function
REQ-019 Each register r SHALL have a counter pend[r] (CNT_W bits), the number of accepted, not yet retired writers of r; pend[0] SHALL always be 0.
REQ-020 On acceptance (in_valid & in_ready) with in_wen and in_dst != 0, pend[in_dst] SHALL increment; on wb_valid with wb_dst != 0 and pend[wb_dst] != 0, pend[wb_dst] SHALL decrement; both on the same register in the same cycle SHALL leave it unchanged; a decrement at 0 SHALL be ignored.
REQ-021 Operand resolution per source s: s == 0 -> zero; pend[s] == 0 -> rf data; else the first match in priority order bypass 0..NUM_BYP-1 (valid & wen & dst == s), then the wb port (wb_valid & wb_dst == s).
REQ-022 A matching source with byp_ready high SHALL supply byp_data; a match with byp_ready low SHALL block (no fall-through to older sources); the wb port is always ready.
REQ-023 pend[s] != 0 with no matching source SHALL block.
REQ-024 in_dst != 0 with in_wen and pend[in_dst] at all-ones SHALL block (counter full).
REQ-025 in_ready = ~flush & ~blocked & (~out_valid | out_ready).
REQ-026 The output register SHALL load on acceptance, giving 1-cycle latency; out_valid SHALL clear when out_ready is high and nothing is accepted; the output register SHALL hold its contents while out_valid & ~out_ready.
REQ-027 flush SHALL, on the next edge, clear all pend[] and out_valid; same-cycle acceptance is prevented by REQ-025.
REQ-028 stall_cycles SHALL increment on each cycle with stall high, saturating at 0xFFFF_FFFF.

Reset
REQ-029 On rst low at a clock edge: all pend[] = 0, out_valid = 0, out_op1/out_op2 = 0, out_dst = 0, out_wen = 0, stall_cycles = 0.
REQ-030 Reset SHALL take priority over flush, acceptance and writeback in the same cycle.

Structure
REQ-031 The types byp_src_t (valid, wen, ready, dst, data) and issue_t (op1, op2, dst, wen) SHALL be defined in instruction_pkg; REG_FILE_LEN and ARCH_LEN SHALL be taken from constants_pkg.
REQ-032 A sub-module operand_resolve (one per source operand, two instances) SHALL implement REQ-021..023.

Verification
REQ-033 Test: accept x5 writer, then x0 writer; in_src1 = 0 -> out_op1 = 0, no stall, pend[0] stays 0.
REQ-034 Test: pend[3] = 1; byp0 dst 3 not ready, byp1 dst 3 ready with 0xAA -> stall high; byp0 ready with 0x55 next cycle -> out_op1 = 0x55.
REQ-035 Test: pend[7] = 1, no bypass match, wb_valid dst 7 data 0x1234 -> forward 0x1234 and pend[7] returns to 0.
REQ-036 Test: 3 accepted writers of x9 with CNT_W = 2, then a 4th -> in_ready low until a wb for x9 occurs.
REQ-037 Test: out_ready low for 4 cycles -> out_* stable, in_ready low, stall_cycles += 4.
REQ-038 Test: flush with pend[4] = 2 and out_valid = 1 -> next cycle pend[] = 0, out_valid = 0; a following wb to x4 is ignored.

Source files
------------

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - architecture-wide sizing constants
package constants_pkg;
    localparam int ARCH_LEN     = 32;
    localparam int REG_FILE_LEN = 32;
endpackage

// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - instruction and bypass-source record types
package instruction_pkg;
    import constants_pkg::*;

    localparam int REG_IDX_W = $clog2(REG_FILE_LEN);

    // One forwarding source as seen by the scoreboard.
    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic                 ready;
        logic [REG_IDX_W-1:0] dst;
        logic [ARCH_LEN-1:0]  data;
    } byp_src_t;

    // Resolved instruction handed to execute.
    typedef struct packed {
        logic [ARCH_LEN-1:0]  op1;
        logic [ARCH_LEN-1:0]  op2;
        logic [REG_IDX_W-1:0] dst;
        logic                 wen;
    } issue_t;
endpackage

// File: rtl/bypass_scoreboard_if.sv
// rtl/bypass_scoreboard_if.sv - decode/bypass/writeback/issue bundle of the scoreboard
// slave  : scoreboard view (drives in_ready, out_*, stall, stall_cycles)
// master : environment view (drives everything else)
interface bypass_scoreboard_if
    import constants_pkg::*;
#(
    parameter int REG_COUNT = REG_FILE_LEN,
    parameter int DATA_W    = ARCH_LEN,
    parameter int NUM_BYP   = 2
);
    localparam int RW = $clog2(REG_COUNT);

    logic                             in_valid;
    logic                             in_ready;
    logic [RW-1:0]                    in_src1;
    logic [RW-1:0]                    in_src2;
    logic [RW-1:0]                    in_dst;
    logic                             in_wen;
    logic [DATA_W-1:0]                rf_data1;
    logic [DATA_W-1:0]                rf_data2;
    logic [NUM_BYP-1:0]               byp_valid;
    logic [NUM_BYP-1:0]               byp_wen;
    logic [NUM_BYP-1:0]               byp_ready;
    logic [NUM_BYP-1:0][RW-1:0]       byp_dst;
    logic [NUM_BYP-1:0][DATA_W-1:0]   byp_data;
    logic                             wb_valid;
    logic [RW-1:0]                    wb_dst;
    logic [DATA_W-1:0]                wb_data;
    logic                             flush;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_W-1:0]                out_op1;
    logic [DATA_W-1:0]                out_op2;
    logic [RW-1:0]                    out_dst;
    logic                             out_wen;
    logic                             stall;
    logic [31:0]                      stall_cycles;

    modport slave (
        input  in_valid, in_src1, in_src2, in_dst, in_wen, rf_data1, rf_data2,
               byp_valid, byp_wen, byp_ready, byp_dst, byp_data,
               wb_valid, wb_dst, wb_data, flush, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_dst, out_wen,
               stall, stall_cycles
    );

    modport master (
        output in_valid, in_src1, in_src2, in_dst, in_wen, rf_data1, rf_data2,
               byp_valid, byp_wen, byp_ready, byp_dst, byp_data,
               wb_valid, wb_dst, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_dst, out_wen,
               stall, stall_cycles
    );
endinterface

// File: rtl/operand_resolve.sv
// rtl/operand_resolve.sv - picks the value of one source operand or flags a hazard
// src_i/pend_nz_i : source index and "has in-flight writer" flag
// rf_data_i       : register-file read data
// byp_*_i         : bypass sources, index 0 youngest
// wb_*_i          : retiring write port
// op_o/block_o    : resolved operand, operand not yet available
module operand_resolve #(
    parameter int RW      = 5,
    parameter int DATA_W  = 32,
    parameter int NUM_BYP = 2
) (
    input  logic [RW-1:0]                  src_i,
    input  logic                           pend_nz_i,
    input  logic [DATA_W-1:0]              rf_data_i,
    input  logic [NUM_BYP-1:0]             byp_valid_i,
    input  logic [NUM_BYP-1:0]             byp_wen_i,
    input  logic [NUM_BYP-1:0]             byp_ready_i,
    input  logic [NUM_BYP-1:0][RW-1:0]     byp_dst_i,
    input  logic [NUM_BYP-1:0][DATA_W-1:0] byp_data_i,
    input  logic                           wb_valid_i,
    input  logic [RW-1:0]                  wb_dst_i,
    input  logic [DATA_W-1:0]              wb_data_i,
    output logic [DATA_W-1:0]              op_o,
    output logic                           block_o
);
    logic found;

    always_comb begin
        op_o    = '0;
        block_o = 1'b0;
        found   = 1'b0;
        if (src_i == '0) begin
            op_o = '0;
        end else if (!pend_nz_i) begin
            op_o = rf_data_i;
        end else begin
            // Youngest matching writer wins; if it has no data yet we must wait
            // rather than take a stale value from an older stage.
            for (int i = 0; i < NUM_BYP; i++) begin
                if (!found && byp_valid_i[i] && byp_wen_i[i] && byp_dst_i[i] == src_i) begin
                    found = 1'b1;
                    if (byp_ready_i[i]) begin
                        op_o = byp_data_i[i];
                    end else begin
                        block_o = 1'b1;
                    end
                end
            end
            if (!found) begin
                if (wb_valid_i && wb_dst_i == src_i) begin
                    op_o = wb_data_i;
                end else begin
                    block_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bypass_scoreboard.sv
// rtl/bypass_scoreboard.sv - per-register writer scoreboard with operand forwarding and issue register
// clk, rst : clock, synchronous active-low reset
// bus      : decode in / bypass / writeback / flush / issue out / stall statistics
module bypass_scoreboard
    import constants_pkg::*;
#(
    parameter int REG_COUNT = REG_FILE_LEN,
    parameter int DATA_W    = ARCH_LEN,
    parameter int NUM_BYP   = 2,
    parameter int CNT_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    bypass_scoreboard_if.slave  bus
);
    localparam int RW = $clog2(REG_COUNT);

    logic [CNT_W-1:0]  pend_q [REG_COUNT];
    logic [CNT_W-1:0]  pend_d [REG_COUNT];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d;
    logic [DATA_W-1:0] out_op2_q, out_op2_d;
    logic [RW-1:0]     out_dst_q, out_dst_d;
    logic              out_wen_q, out_wen_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic [DATA_W-1:0] op1, op2;
    logic              blk1, blk2, full, blocked, accept, in_ready;

    operand_resolve #(.RW(RW), .DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) u_res1 (
        .src_i       (bus.in_src1),
        .pend_nz_i   (|pend_q[bus.in_src1]),
        .rf_data_i   (bus.rf_data1),
        .byp_valid_i (bus.byp_valid),
        .byp_wen_i   (bus.byp_wen),
        .byp_ready_i (bus.byp_ready),
        .byp_dst_i   (bus.byp_dst),
        .byp_data_i  (bus.byp_data),
        .wb_valid_i  (bus.wb_valid),
        .wb_dst_i    (bus.wb_dst),
        .wb_data_i   (bus.wb_data),
        .op_o        (op1),
        .block_o     (blk1)
    );

    operand_resolve #(.RW(RW), .DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) u_res2 (
        .src_i       (bus.in_src2),
        .pend_nz_i   (|pend_q[bus.in_src2]),
        .rf_data_i   (bus.rf_data2),
        .byp_valid_i (bus.byp_valid),
        .byp_wen_i   (bus.byp_wen),
        .byp_ready_i (bus.byp_ready),
        .byp_dst_i   (bus.byp_dst),
        .byp_data_i  (bus.byp_data),
        .wb_valid_i  (bus.wb_valid),
        .wb_dst_i    (bus.wb_dst),
        .wb_data_i   (bus.wb_data),
        .op_o        (op2),
        .block_o     (blk2)
    );

    // A saturated counter cannot track one more writer.
    assign full     = bus.in_wen && (bus.in_dst != '0) && (&pend_q[bus.in_dst]);
    assign blocked  = blk1 | blk2 | full;
    assign in_ready = ~bus.flush & ~blocked & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < REG_COUNT; r++) begin
            logic inc, dec;
            inc = accept && bus.in_wen && (bus.in_dst == RW'(r));
            dec = bus.wb_valid && (bus.wb_dst == RW'(r)) && (pend_q[r] != '0);
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - CNT_W'(1);
            end
        end
        pend_d[0] = '0;
        if (bus.flush) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                pend_d[r] = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_dst_d   = out_dst_q;
        out_wen_d   = out_wen_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_op1_d   = op1;
            out_op2_d   = op2;
            out_dst_d   = bus.in_dst;
            out_wen_d   = bus.in_wen;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.stall = bus.in_valid & ~in_ready;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                pend_q[r] <= '0;
            end
            out_valid_q    <= 1'b0;
            out_op1_q      <= '0;
            out_op2_q      <= '0;
            out_dst_q      <= '0;
            out_wen_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                pend_q[r] <= pend_d[r];
            end
            out_valid_q    <= out_valid_d;
            out_op1_q      <= out_op1_d;
            out_op2_q      <= out_op2_d;
            out_dst_q      <= out_dst_d;
            out_wen_q      <= out_wen_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_op1      = out_op1_q;
    assign bus.out_op2      = out_op2_q;
    assign bus.out_dst      = out_dst_q;
    assign bus.out_wen      = out_wen_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb/tb_bypass_scoreboard.sv - directed self-checking bench for bypass_scoreboard
module tb_bypass_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bypass_scoreboard_if #(.REG_COUNT(32), .DATA_W(32), .NUM_BYP(2)) bif ();

    bypass_scoreboard #(.REG_COUNT(32), .DATA_W(32), .NUM_BYP(2), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.in_valid  = 1'b0;
        bif.in_src1   = '0;
        bif.in_src2   = '0;
        bif.in_dst    = '0;
        bif.in_wen    = 1'b0;
        bif.rf_data1  = '0;
        bif.rf_data2  = '0;
        bif.byp_valid = '0;
        bif.byp_wen   = '0;
        bif.byp_ready = '0;
        bif.byp_dst   = '0;
        bif.byp_data  = '0;
        bif.wb_valid  = 1'b0;
        bif.wb_dst    = '0;
        bif.wb_data   = '0;
        bif.flush     = 1'b0;
    endtask

    task automatic writer(input logic [4:0] dst);
        idle();
        bif.in_valid = 1'b1;
        bif.in_wen   = 1'b1;
        bif.in_dst   = dst;
    endtask

    initial begin
        idle();
        bif.out_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_out_op1", bif.out_op1, 32'd0);
        chk("rst_out_op2", bif.out_op2, 32'd0);
        chk("rst_out_dst", 32'(bif.out_dst), 32'd0);
        chk("rst_out_wen", 32'(bif.out_wen), 32'd0);
        chk("rst_stall_cycles", bif.stall_cycles, 32'd0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
        rst = 1'b1;

        // x5 writer then x0 writer with src1 = 0
        writer(5'd5);
        bif.rf_data1 = 32'h1111;
        #1;
        chk("x5_in_ready", 32'(bif.in_ready), 32'd1);
        tick();
        chk("x5_out_valid", 32'(bif.out_valid), 32'd1);
        chk("x5_out_dst", 32'(bif.out_dst), 32'd5);
        chk("x5_out_wen", 32'(bif.out_wen), 32'd1);
        chk("x5_out_op1_zero", bif.out_op1, 32'd0);
        writer(5'd0);
        bif.rf_data1 = 32'hDEAD;
        #1;
        chk("x0_stall", 32'(bif.stall), 32'd0);
        tick();
        chk("x0_out_op1", bif.out_op1, 32'd0);
        chk("x0_out_dst", 32'(bif.out_dst), 32'd0);
        // another reader of x0 must still see zero and never stall
        idle();
        bif.in_valid = 1'b1;
        bif.rf_data1 = 32'hBAD0;
        #1;
        chk("x0_read_stall", 32'(bif.stall), 32'd0);
        tick();
        chk("x0_read_op1", bif.out_op1, 32'd0);

        // byp0 not ready must block even though byp1 has data
        writer(5'd3);
        tick();
        idle();
        bif.in_valid     = 1'b1;
        bif.in_src1      = 5'd3;
        bif.rf_data1     = 32'h3333;
        bif.byp_valid    = 2'b11;
        bif.byp_wen      = 2'b11;
        bif.byp_dst[0]   = 5'd3;
        bif.byp_dst[1]   = 5'd3;
        bif.byp_ready    = 2'b10;
        bif.byp_data[1]  = 32'hAA;
        #1;
        chk("byp_stall", 32'(bif.stall), 32'd1);
        chk("byp_in_ready", 32'(bif.in_ready), 32'd0);
        tick();
        bif.byp_ready    = 2'b11;
        bif.byp_data[0]  = 32'h55;
        #1;
        chk("byp_ready_stall", 32'(bif.stall), 32'd0);
        tick();
        chk("byp_out_op1", bif.out_op1, 32'h55);
        chk("byp_stall_cnt", bif.stall_cycles, 32'd1);

        // writeback forwarding for x7, then pend[7] back to 0
        writer(5'd7);
        tick();
        idle();
        bif.in_valid = 1'b1;
        bif.in_src1  = 5'd7;
        bif.rf_data1 = 32'h7777;
        bif.wb_valid = 1'b1;
        bif.wb_dst   = 5'd7;
        bif.wb_data  = 32'h1234;
        #1;
        chk("wb_in_ready", 32'(bif.in_ready), 32'd1);
        tick();
        chk("wb_out_op1", bif.out_op1, 32'h1234);
        bif.wb_valid = 1'b0;
        #1;
        chk("x7_clear_in_ready", 32'(bif.in_ready), 32'd1);
        tick();
        chk("x7_rf_op1", bif.out_op1, 32'h7777);

        // counter full on the 4th writer of x9
        for (int i = 0; i < 3; i++) begin
            writer(5'd9);
            #1;
            chk("x9_accept_ready", 32'(bif.in_ready), 32'd1);
            tick();
        end
        writer(5'd9);
        #1;
        chk("x9_full_ready", 32'(bif.in_ready), 32'd0);
        chk("x9_full_stall", 32'(bif.stall), 32'd1);
        tick();
        chk("x9_full_ready_hold", 32'(bif.in_ready), 32'd0);
        tick();
        bif.wb_valid = 1'b1;
        bif.wb_dst   = 5'd9;
        bif.wb_data  = 32'h9999;
        #1;
        chk("x9_wb_cycle_ready", 32'(bif.in_ready), 32'd0);
        tick();
        bif.wb_valid = 1'b0;
        #1;
        chk("x9_after_wb_ready", 32'(bif.in_ready), 32'd1);
        tick();
        chk("x9_out_dst", 32'(bif.out_dst), 32'd9);
        chk("x9_stall_cnt", bif.stall_cycles, 32'd4);

        // output back-pressure for 4 cycles
        idle();
        bif.in_valid = 1'b1;
        bif.in_dst   = 5'd12;
        bif.in_src2  = 5'd13;
        bif.rf_data2 = 32'hBEEF;
        tick();
        chk("bp_first_op2", bif.out_op2, 32'hBEEF);
        bif.out_ready = 1'b0;
        bif.in_dst    = 5'd14;
        bif.in_src2   = 5'd14;
        bif.rf_data2  = 32'hCAFE;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
            tick();
            chk("bp_out_op2", bif.out_op2, 32'hBEEF);
            chk("bp_out_dst", 32'(bif.out_dst), 32'd12);
            chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
        end
        chk("bp_stall_cnt", bif.stall_cycles, 32'd8);
        bif.out_ready = 1'b1;
        tick();
        chk("bp_release_op2", bif.out_op2, 32'hCAFE);
        chk("bp_release_dst", 32'(bif.out_dst), 32'd14);

        // flush with pend[4] = 2 and out_valid = 1
        writer(5'd4);
        tick();
        writer(5'd4);
        tick();
        chk("fl_pre_out_valid", 32'(bif.out_valid), 32'd1);
        idle();
        bif.flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(bif.in_ready), 32'd0);
        tick();
        chk("fl_out_valid", 32'(bif.out_valid), 32'd0);
        idle();
        bif.wb_valid = 1'b1;
        bif.wb_dst   = 5'd4;
        bif.wb_data  = 32'h4040;
        tick();
        idle();
        bif.in_valid = 1'b1;
        bif.in_src1  = 5'd4;
        bif.rf_data1 = 32'h4444;
        bif.in_src2  = 5'd3;
        bif.rf_data2 = 32'h3333;
        #1;
        chk("fl_reader_ready", 32'(bif.in_ready), 32'd1);
        tick();
        chk("fl_reader_op1", bif.out_op1, 32'h4444);
        chk("fl_reader_op2", bif.out_op2, 32'h3333);
        chk("fl_stall_cnt", bif.stall_cycles, 32'd8);

        // reset wins over a same-cycle acceptance
        writer(5'd6);
        rst = 1'b0;
        tick();
        chk("rst_acc_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_acc_out_dst", 32'(bif.out_dst), 32'd0);
        chk("rst_acc_stall_cnt", bif.stall_cycles, 32'd0);
        rst = 1'b1;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
